// File: rtl/serial_compare_ctrl_if.sv
// Start/done request bus for serial_compare_ctrl: operands in, busy/done and result flags out.
interface serial_compare_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             et;

  modport master (
    output start, A, B,
    input  busy, done, gt, lt, et
  );

  modport slave (
    input  start, A, B,
    output busy, done, gt, lt, et
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Serial unsigned magnitude compare, one 2-bit slice per cycle, MSB slice first.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first unequal slice.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_compare_ctrl_if.slave  bus
);

  localparam int unsigned SLICES = WIDTH / 2;
  localparam int unsigned IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_compare_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDXW-1:0]  idx;
  logic             dec;
  logic             dec_gt;

  logic [1:0]       a_sl_c;
  logic [1:0]       b_sl_c;
  logic             nxt_dec_c;
  logic             nxt_gt_c;
  logic             finish_c;

  // Current slice compare; an earlier (more significant) decision always wins.
  always_comb begin
    a_sl_c    = 2'(a_reg >> {idx, 1'b0});
    b_sl_c    = 2'(b_reg >> {idx, 1'b0});
    nxt_dec_c = dec | (a_sl_c != b_sl_c);
    nxt_gt_c  = dec ? dec_gt : (a_sl_c > b_sl_c);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish_c  = (idx == '0) || nxt_dec_c;
`else
    finish_c  = (idx == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      dec      <= 1'b0;
      dec_gt   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.gt   <= 1'b0;
      bus.lt   <= 1'b0;
      bus.et   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          if (bus.start) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            idx      <= LAST_IDX;
            dec      <= 1'b0;
            dec_gt   <= 1'b0;
            bus.gt   <= 1'b0;
            bus.lt   <= 1'b0;
            bus.et   <= 1'b0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          dec    <= nxt_dec_c;
          dec_gt <= nxt_gt_c;
          if (finish_c) begin
            bus.gt   <= nxt_dec_c & nxt_gt_c;
            bus.lt   <= nxt_dec_c & ~nxt_gt_c;
            bus.et   <= ~nxt_dec_c;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx - IDXW'(1);
          end
        end
        DONE: begin
          // Flags stay held until the next accepted start.
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl (WIDTH=8); honours SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_compare_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = WIDTH / 2;

  typedef struct {
    logic gt;
    logic lt;
    logic et;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: full-width compare; latency is the slice count up to the first difference.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t r;
    r.gt  = (a > b);
    r.lt  = (a < b);
    r.et  = (a == b);
    r.lat = int'(N);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (a[2*i +: 2] != b[2*i +: 2]) begin
        r.lat = int'(N) - i;
        break;
      end
    end
`endif
    return r;
  endfunction

  // Called #1 after the start edge; counts edges until done, noting any early flag activity.
  task automatic wait_done(output int lat, output bit flags_early);
    lat = -1;
    flags_early = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = e;
        break;
      end
      if ((bus.gt | bus.lt | bus.et) !== 1'b0) flags_early = 1'b1;
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   lat;
    bit   fl;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.A = 8'hFF;
    bus.B = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if ({bus.gt, bus.lt, bus.et} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got gt/lt/et=%b want 000", {bus.gt, bus.lt, bus.et});
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h00, 8'h00);
    wait_done(lat, fl);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL reset_op_latency: got %0d want %0d", lat, e.lat); end
    checks++; if ({bus.gt, bus.lt, bus.et} !== {e.gt, e.lt, e.et}) begin
      errors++; $display("FAIL reset_op_flags: got %b want %b", {bus.gt, bus.lt, bus.et}, {e.gt, e.lt, e.et});
    end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL reset_op_flags_during_run: got %b want 0", fl); end
    @(posedge clk); #1;
    checks++; if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL reset_op_single_pulse: got done/busy=%b want 00", {bus.done, bus.busy});
    end
    checks++; if (bus.et !== 1'b1) begin errors++; $display("FAIL reset_op_hold: got et=%b want 1", bus.et); end
  endtask

  task automatic test_ordering();
    logic [WIDTH-1:0] va[6] = '{8'h40, 8'h3F, 8'hFF, 8'hA5, 8'h01, 8'h00};
    logic [WIDTH-1:0] vb[6] = '{8'h3F, 8'h40, 8'h00, 8'hA4, 8'h00, 8'h01};
    exp_t e;
    int   lat;
    bit   fl;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i]);
      wait_done(lat, fl);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin
        errors++; $display("FAIL ordering_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      end
      checks++; if ({bus.gt, bus.lt, bus.et} !== {e.gt, e.lt, e.et}) begin
        errors++; $display("FAIL ordering_flags[%0d] A=%h B=%h: got %b want %b",
                           i, va[i], vb[i], {bus.gt, bus.lt, bus.et}, {e.gt, e.lt, e.et});
      end
      checks++; if (fl !== 1'b0) begin errors++; $display("FAIL ordering_flags_during_run[%0d]: got 1 want 0", i); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_exit();
    exp_t e;
    int   lat;
    bit   fl;
    int   want;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    want = 1;
`else
    want = int'(N);
`endif
    issue(8'hC0, 8'h00);
    wait_done(lat, fl);
    e = sb.pop_front();
    checks++; if (lat != want) begin errors++; $display("FAIL early_latency_const: got %0d want %0d", lat, want); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL early_latency_model: got %0d want %0d", lat, e.lat); end
    checks++; if ({bus.gt, bus.lt, bus.et} !== 3'b100) begin
      errors++; $display("FAIL early_flags: got %b want 100", {bus.gt, bus.lt, bus.et});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   fl;
    bus.A = 8'h10;
    bus.B = 8'h20;
    bus.start = 1'b1;
    sb.push_back(model(8'h10, 8'h20));
    @(posedge clk); #1;
    lat = -1;
    // start held high and operands scrambled while busy: neither may affect the result
    for (int c = 1; c <= 20; c++) begin
      bus.A = WIDTH'($urandom);
      bus.B = WIDTH'($urandom);
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin lat = c; break; end
    end
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, e.lat); end
    checks++; if ({bus.gt, bus.lt, bus.et} !== {e.gt, e.lt, e.et}) begin
      errors++; $display("FAIL b2b_first_flags: got %b want %b", {bus.gt, bus.lt, bus.et}, {e.gt, e.lt, e.et});
    end
    bus.A = 8'h20;
    bus.B = 8'h10;
    sb.push_back(model(8'h20, 8'h10));
    @(posedge clk); #1;
    checks++; if ({bus.busy, bus.done, bus.lt} !== 3'b001) begin
      errors++; $display("FAIL b2b_idle_gap: got busy/done/lt=%b want 001", {bus.busy, bus.done, bus.lt});
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if ({bus.busy, bus.gt, bus.lt, bus.et} !== 4'b1000) begin
      errors++; $display("FAIL b2b_second_accept: got busy/gt/lt/et=%b want 1000", {bus.busy, bus.gt, bus.lt, bus.et});
    end
    wait_done(lat, fl);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, e.lat); end
    checks++; if ({bus.gt, bus.lt, bus.et} !== {e.gt, e.lt, e.et}) begin
      errors++; $display("FAIL b2b_second_flags: got %b want %b", {bus.gt, bus.lt, bus.et}, {e.gt, e.lt, e.et});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   lat;
    bit   fl;
    bit   seen_done;
    bus.A = 8'h3C;
    bus.B = 8'h3D;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL midrst_busy_done: got %b want 00", {bus.busy, bus.done});
    end
    checks++; if ({bus.gt, bus.lt, bus.et} !== 3'b000) begin
      errors++; $display("FAIL midrst_flags: got %b want 000", {bus.gt, bus.lt, bus.et});
    end
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got pulse want none"); end
    issue(8'h3D, 8'h3C);
    wait_done(lat, fl);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL midrst_fresh_latency: got %0d want %0d", lat, e.lat); end
    checks++; if ({bus.gt, bus.lt, bus.et} !== {e.gt, e.lt, e.et}) begin
      errors++; $display("FAIL midrst_fresh_flags: got %b want %b", {bus.gt, bus.lt, bus.et}, {e.gt, e.lt, e.et});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_ordering();
    test_early_exit();
    test_back_to_back();
    test_reset_mid_run();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
